data_mem_resp: RTL and testbench
================================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, wait states inserted before the response (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  1  initiator request valid; held high until ready.
REQ-006 SHALL have port memrw  input  1  1 = store, 0 = load.
REQ-007 SHALL have port addr  input  32  byte address (memory-stage ALU result).
REQ-008 SHALL have port wdata  input  32  store data, right-aligned.
REQ-009 SHALL have port funct3  input  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have port rdata  output  32  load result, extended per funct3.
REQ-011 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  misaligned/illegal-size flag, valid with ready.

Function
REQ-013 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; IDLE -> RESP directly when WAIT_CYCLES = 0.
REQ-014 SHALL accept a request in IDLE when req = 1, capturing addr, memrw, wdata and funct3 into internal registers.
REQ-015 SHALL ignore input changes after acceptance; the captured request completes even if req drops.
REQ-016 SHALL stay in WAIT for exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter.
REQ-017 SHALL assert ready for exactly one cycle in RESP; accept-to-ready latency = WAIT_CYCLES + 1 cycles.
REQ-018 SHALL not accept a new request in the RESP cycle; earliest next acceptance is the cycle after ready.
REQ-019 SHALL index the memory with addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored (aliasing wrap-around).
REQ-020 SHALL commit stores only on the RESP edge, updating only the addressed byte lanes (SB 1 lane, SH 2 lanes, SW 4 lanes).
REQ-021 SHALL return on loads: LB/LH sign-extended, LBU/LHU zero-extended, LW unchanged, lane selected by addr[1:0].
REQ-022 SHALL hold rdata from the last load until the next load completes; stores leave rdata unchanged.
REQ-023 SHALL treat funct3 values 011, 110, 111, and stores with funct3 bit 2 set, as illegal: err = 1, no write, rdata = 0.
REQ-024 SHALL drive err = 0 outside the ready cycle.

Reset
REQ-025 SHALL on rst force state IDLE, counter 0, ready 0, err 0, rdata 0x00000000.
REQ-026 SHALL abort any in-flight request on rst; a store aborted before its RESP edge leaves memory unchanged.
REQ-027 SHALL not clear memory contents on reset.
REQ-028 SHALL give rst priority over a simultaneous req.

Configuration
REQ-029 SHALL use macro DMEM_MISALIGN_TRAP_EN.
REQ-030 SHALL, with DMEM_MISALIGN_TRAP_EN defined, flag halfword accesses with addr[0] = 1 and word accesses with addr[1:0] != 0 as err = 1 with no write and rdata = 0.
REQ-031 SHALL, without the macro, force alignment down (halfword ignores addr[0], word ignores addr[1:0]) and never flag misalignment; illegal funct3 is still flagged.

Verification
REQ-032 SHALL cover SW 0xDEADBEEF to 0x10 then LW 0x10 with WAIT_CYCLES = 1 -> ready 2 cycles after each acceptance, rdata = 0xDEADBEEF, err = 0.
REQ-033 SHALL cover SB 0x80 to 0x13, then LB 0x13 -> 0xFFFFFF80, LBU 0x13 -> 0x00000080, LW 0x10 -> 0x80ADBEEF.
REQ-034 SHALL cover LH 0x11 with the macro -> err = 1, rdata = 0; without it -> rdata = sign-extended halfword at 0x10.
REQ-035 SHALL cover LW 0x1010 with DEPTH_WORDS = 1024 -> same data as 0x10 (alias).
REQ-036 SHALL cover SW 0x12345678 to 0x20 with rst asserted in WAIT -> ready never pulses, later LW 0x20 returns the prior value.
REQ-037 SHALL cover back-to-back requests with req held high -> ready pulses separated by WAIT_CYCLES + 2 cycles.

Source files
------------

// File: rtl/data_mem_resp.sv
// data_mem_resp: single-port data memory with a fixed-latency response
// handshake for an RV32I memory stage. A request is captured in IDLE,
// optionally held in WAIT for WAIT_CYCLES cycles, and answered with a
// one-cycle ready pulse in RESP. Stores commit on the RESP edge.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (flag misaligned
// halfword/word accesses instead of forcing alignment down).
module data_mem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        memrw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam int         AQ_W      = IDX_W + 2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              accept;
    logic [AQ_W-1:0]   addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        funct3_q;
    logic              memrw_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [31:0]       mem [DEPTH_WORDS];

    // Address bits above the memory index alias onto the same words.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AQ_W];

    // Illegal size encodings, stores with the unsigned bit, and (optionally) misalignment.
    function automatic logic access_bad(input logic [2:0] f3, input logic rw, input logic [1:0] a);
        logic bad;
        bad = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (rw && f3[2]);
`ifdef DMEM_MISALIGN_TRAP_EN
        bad = bad || ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
`else
        bad = bad || (a == 2'b11 && 1'b0);
`endif
        return bad;
    endfunction

    // Byte offset of the accessed lane group; halfwords/words are forced aligned.
    function automatic logic [1:0] lane_off(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return a;
            2'b01:   return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    // Byte-lane write enables for SB/SH/SW.
    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Select the addressed lane(s) and sign/zero-extend the load result.
    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b010:  return sh;
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    // In IDLE the live inputs describe the request being accepted (needed when
    // WAIT_CYCLES = 0 and the response is formed on the acceptance edge).
    logic            in_idle;
    logic [AQ_W-1:0] cur_addr;
    logic [2:0]      cur_f3;
    logic            cur_rw;
    logic            cur_bad;
    logic            enter_resp;
    logic [1:0]      wr_off;
    logic [3:0]      wr_be;
    logic [31:0]     wr_data;
    logic            wr_en;

    assign in_idle    = (state_q == S_IDLE);
    assign cur_addr   = in_idle ? addr[AQ_W-1:0] : addr_q;
    assign cur_f3     = in_idle ? funct3 : funct3_q;
    assign cur_rw     = in_idle ? memrw : memrw_q;
    assign cur_bad    = access_bad(cur_f3, cur_rw, cur_addr[1:0]);
    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

    assign wr_off  = lane_off(funct3_q, addr_q[1:0]);
    assign wr_be   = byte_en(funct3_q, wr_off);
    assign wr_data = wdata_q << {wr_off, 3'b000};
    assign wr_en   = (state_q == S_RESP) && memrw_q && !err_q && !rst;

    assign ready = (state_q == S_RESP);
    assign rdata = rdata_q;
    assign err   = err_q;

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, counter and response registers; reset aborts any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= enter_resp && cur_bad;
            if (enter_resp) begin
                if (cur_bad) begin
                    rdata_q <= 32'h0;
                end else if (!cur_rw) begin
                    rdata_q <= load_ext(mem[cur_addr[AQ_W-1:2]], cur_f3,
                                        lane_off(cur_f3, cur_addr[1:0]));
                end
            end
        end
    end

    // Request capture; inputs are ignored once the request is accepted.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            addr_q   <= addr[AQ_W-1:0];
            wdata_q  <= wdata;
            funct3_q <= funct3;
            memrw_q  <= memrw;
        end
    end

    // Store commit on the RESP edge, per byte lane; memory is never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[addr_q[AQ_W-1:2]][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Testbench for data_mem_resp: scoreboard of expected responses produced by a
// byte-array reference model, popped when the DUT pulses ready.
module tb_data_mem_resp;

    localparam int DEPTH = 1024;
    localparam int WAITC = 1;
    localparam int BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        memrw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    data_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .rst(rst), .req(req), .memrw(memrw), .addr(addr),
        .wdata(wdata), .funct3(funct3), .rdata(rdata), .ready(ready), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd;
        logic        e;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [31:0] obs_rdata = 32'h0;
    logic [31:0] last_rd = 32'h0;
    logic [7:0]  mref [0:BYTES-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model of one access; updates the model memory and last load value.
    task automatic model(input logic rw, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, output logic [31:0] erd, output logic eerr);
        int n;
        int b;
        logic [31:0] v;
        logic bad;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (rw && f3[2]);
`ifdef DMEM_MISALIGN_TRAP_EN
        bad = bad || (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
`endif
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        b = int'(a & 32'(BYTES - 1)) & ~(n - 1);
        if (bad) begin
            last_rd = 32'h0;
            erd = 32'h0;
            eerr = 1'b1;
        end else if (rw) begin
            for (int i = 0; i < n; i++) mref[b + i] = wd[8*i +: 8];
            erd = last_rd;
            eerr = 1'b0;
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mref[b + i];
            if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
            if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
            last_rd = v;
            erd = v;
            eerr = 1'b0;
        end
    endtask

    // Response monitor: pops the scoreboard on each ready pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (ready) begin
                obs_rdata = rdata;
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rdata", rdata, mon_e.rd);
                    chk("err", {31'b0, err}, {31'b0, mon_e.e});
                end
            end else begin
                chk("err_idle", {31'b0, err}, 32'd0);
            end
        end
    end

    // Wait (bounded) for ready at negedges; returns the cycle it was seen in.
    task automatic wait_ready(input string tag, output int seen);
        int k;
        k = 0;
        seen = -1;
        while (seen < 0 && k < 40) begin
            if (ready) seen = cyc;
            else begin
                @(negedge clk);
                k++;
            end
        end
        if (seen < 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // One request; starts and ends at a negedge with the DUT idle.
    task automatic do_req(input logic rw, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3);
        exp_t e;
        int c0;
        int seen;
        model(rw, a, wd, f3, e.rd, e.e);
        exp_q.push_back(e);
        req = 1'b1; memrw = rw; addr = a; wdata = wd; funct3 = f3;
        c0 = cyc;
        @(negedge clk);
        req = 1'b0;
        memrw = 1'($urandom); addr = $urandom; wdata = $urandom;
        funct3 = 3'($urandom_range(0, 7));
        wait_ready("req", seen);
        if (seen >= 0) chk("latency", 32'(seen - c0), 32'(WAITC + 1));
        @(negedge clk);
    endtask

    initial begin
        int r1;
        int r2;
        exp_t e;
        rst = 1'b1; req = 1'b0; memrw = 1'b0; addr = 32'h0; wdata = 32'h0; funct3 = 3'b010;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Word store/load round trip.
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
        do_req(1'b0, 32'h10, 32'h0, 3'b010);
        chk("lw10", obs_rdata, 32'hDEADBEEF);

        // Byte store and signed/unsigned byte loads.
        do_req(1'b1, 32'h13, 32'h00000080, 3'b000);
        do_req(1'b0, 32'h13, 32'h0, 3'b000);
        chk("lb13", obs_rdata, 32'hFFFFFF80);
        do_req(1'b0, 32'h13, 32'h0, 3'b100);
        chk("lbu13", obs_rdata, 32'h00000080);
        do_req(1'b0, 32'h10, 32'h0, 3'b010);
        chk("lw10_b", obs_rdata, 32'h80ADBEEF);

        // Misaligned halfword load.
        do_req(1'b0, 32'h11, 32'h0, 3'b001);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("lh11_trap", obs_rdata, 32'h0);
`else
        chk("lh11_align", obs_rdata, 32'hFFFFBEEF);
`endif
        do_req(1'b0, 32'h12, 32'h0, 3'b101);
        chk("lhu12", obs_rdata, 32'h000080AD);

        // Halfword store into upper lanes.
        do_req(1'b1, 32'h14, 32'hCAFEF00D, 3'b010);
        do_req(1'b1, 32'h16, 32'hFFFF7A5B, 3'b001);
        do_req(1'b0, 32'h14, 32'h0, 3'b010);
        chk("lw14", obs_rdata, 32'h7A5BF00D);

        // Address aliasing above the memory size.
        do_req(1'b0, 32'h1010, 32'h0, 3'b010);
        chk("lw_alias", obs_rdata, 32'h80ADBEEF);

        // Illegal size on load, then a store that must keep rdata.
        do_req(1'b0, 32'h10, 32'h0, 3'b011);
        chk("illegal_rd", obs_rdata, 32'h0);
        do_req(1'b1, 32'h20, 32'h11111111, 3'b010);
        chk("store_keeps_rdata", rdata, 32'h0);
        do_req(1'b1, 32'h10, 32'h000000FF, 3'b100);
        do_req(1'b0, 32'h10, 32'h0, 3'b010);
        chk("illegal_st_nowrite", obs_rdata, 32'h80ADBEEF);

        // Reset during WAIT aborts a store.
        req = 1'b1; memrw = 1'b1; addr = 32'h20; wdata = 32'h12345678; funct3 = 3'b010;
        @(negedge clk);
        req = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_rd = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("abort_no_ready", {31'b0, ready}, 32'd0);
            @(negedge clk);
        end
        chk("abort_rdata", rdata, 32'h0);
        do_req(1'b0, 32'h20, 32'h0, 3'b010);
        chk("lw20_prior", obs_rdata, 32'h11111111);

        // Reset has priority over a simultaneous request.
        rst = 1'b1; req = 1'b1; memrw = 1'b0; addr = 32'h10; funct3 = 3'b010;
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rst_prio_no_ready", {31'b0, ready}, 32'd0);
            @(negedge clk);
        end
        last_rd = 32'h0;

        // Back-to-back loads with req held high.
        model(1'b0, 32'h10, 32'h0, 3'b010, e.rd, e.e);
        exp_q.push_back(e);
        model(1'b0, 32'h10, 32'h0, 3'b010, e.rd, e.e);
        exp_q.push_back(e);
        req = 1'b1; memrw = 1'b0; addr = 32'h10; funct3 = 3'b010;
        @(negedge clk);
        wait_ready("b2b1", r1);
        @(negedge clk);
        wait_ready("b2b2", r2);
        req = 1'b0;
        if (r1 >= 0 && r2 >= 0) chk("b2b_gap", 32'(r2 - r1), 32'(WAITC + 2));
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
